// File: rtl/step_run_ctrl.sv
// rtl/step_run_ctrl.sv - run/single-step clock-enable controller with retire counter, step LED and timeout flag
module step_run_ctrl #(
    parameter int TIMEOUT  = 16,
    parameter int LED_HOLD = 2500000,
    parameter int CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             step_req,
    input  logic             singlestep,
    input  logic             instr_done,
    output logic             cpu_en,
    output logic             step_ack,
    output logic             busy,
    output logic [CNT_W-1:0] step_cnt,
    output logic             timeout,
    output logic             led
);

    localparam int WW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam int LW = (LED_HOLD > 1) ? $clog2(LED_HOLD + 1) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_WAIT,
        S_ACK
    } state_t;

    state_t           state_q, state_d;
    logic [WW-1:0]    wait_q, wait_d;
    logic [LW-1:0]    led_cnt_q, led_cnt_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             tmo_q, tmo_d;

    assign cpu_en   = (state_q == S_RUN) || (state_q == S_WAIT);
    assign busy     = (state_q == S_WAIT) || (state_q == S_ACK);
    assign step_ack = (state_q == S_ACK);
    assign step_cnt = cnt_q;
    assign timeout  = tmo_q;
    assign led      = (led_cnt_q != '0);

    always_comb begin
        state_d   = state_q;
        wait_d    = wait_q;
        tmo_d     = tmo_q;
        cnt_d     = cnt_q;
        led_cnt_d = (led_cnt_q != '0) ? led_cnt_q - LW'(1) : led_cnt_q;

        unique case (state_q)
            S_IDLE: begin
                if (!singlestep) begin
                    state_d = S_RUN;
                end else if (step_req) begin
                    state_d = S_WAIT;
                    wait_d  = '0;
                end
            end
            S_RUN: begin
                // Leaving run mode only on a retire keeps the core on an instruction boundary.
                if (singlestep && instr_done) begin
                    state_d = S_IDLE;
                end
            end
            S_WAIT: begin
                if (instr_done) begin
                    state_d = S_ACK;
                end else if (wait_q == WW'(TIMEOUT - 1)) begin
                    state_d = S_ACK;
                    tmo_d   = 1'b1;
                end else begin
                    wait_d = wait_q + WW'(1);
                end
            end
            S_ACK: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (state_q == S_WAIT && state_d == S_ACK) begin
            led_cnt_d = LW'(LED_HOLD);
        end

        if (instr_done && cpu_en) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            wait_q    <= '0;
            led_cnt_q <= '0;
            cnt_q     <= '0;
            tmo_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            wait_q    <= wait_d;
            led_cnt_q <= led_cnt_d;
            cnt_q     <= cnt_d;
            tmo_q     <= tmo_d;
        end
    end

endmodule
